weyl_sng_stream: RTL

- Sequential, multi-channel successor to the combinational Weyl quota table.
- Accepts one quota per channel and streams a BITSTREAM-long stochastic bitstream per channel, LANES bits per beat, over a valid/ready handshake.
- Each channel uses its own base and stride, so streams are decorrelated. A mode selects Weyl-scattered or thermometer (unary) layout.
- Sits between the quota/weight source and the stochastic-computing MAC array.

---
 rtl/weyl_pkg.sv | 37 +++
 rtl/weyl_lane_gen.sv | 77 +++++++
 rtl/weyl_sng_stream.sv | 117 +++++++++++
 3 files changed

// File: rtl/weyl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : weyl_pkg
// Purpose  : Shared types and constant helpers for the Weyl bitstream generator.
// Revision : 1.0 - initial release
// ============================================================================
package weyl_pkg;

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
   typedef enum logic {WEYL = 1'b0, THERMO = 1'b1} mode_t;

   // Newton iteration doubles the number of correct low bits each pass;
   // an odd s is its own inverse mod 8, so five passes cover 32 bits.
   function automatic int modinv_pow2(input int s, input int n);
      int x;
      x = s;
      for (int i = 0; i < 5; i++) begin
         x = x * (2 - s * x);
      end
      return x & (n - 1);
   endfunction

   function automatic int chan_stride(input int stride, input int c);
      return stride + 4 * c;
   endfunction

   function automatic int chan_base(input int base, input int step, input int c, input int n);
      return (base + c * step) % n;
   endfunction

   // Index of stream position 0: ((0 - base) * sinv) mod n.
   function automatic int chan_idx0(input int base, input int sinv, input int n);
      return (((n - base) % n) * sinv) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/weyl_lane_gen.sv
`default_nettype none
// ============================================================================
// Module   : weyl_lane_gen
// Purpose  : One channel's Weyl index accumulator and per-lane quota comparators.
// Revision : 1.0 - initial release
// ============================================================================
module weyl_lane_gen
   import weyl_pkg::*;
#(
   parameter int N     = 64,
   parameter int LANES = 8,
   parameter int SINV  = 49,
   parameter int IDX0  = 19,
   parameter int IW    = $clog2(N),
   parameter int QW    = $clog2(N) + 1,
   parameter int BW    = $clog2(N / LANES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic             mode,
   input  logic [QW-1:0]    quota,
   input  logic [BW-1:0]    nxt_beat,
   output logic [LANES-1:0] bits
);

   localparam int            LW     = $clog2(LANES);
   localparam logic [IW-1:0] C_STEP = IW'((LANES * SINV) % N);
   localparam logic [IW-1:0] C_IDX0 = IW'(IDX0);

   // r_acc always holds the index of lane 0 for the beat computed next
   logic [IW-1:0]    r_acc;
   logic [QW-1:0]    r_quota;
   mode_t            r_mode;
   logic [IW-1:0]    w_acc;
   logic [QW-1:0]    w_quota;
   mode_t            w_mode;
   logic [IW-1:0]    w_pbase;
   logic [LANES-1:0] w_bits;

   always_comb begin
      w_acc   = start ? C_IDX0 : r_acc;
      w_quota = r_quota;
      if (start) begin
         w_quota = (quota > QW'(N)) ? QW'(N) : quota;
      end
      w_mode  = start ? mode_t'(mode) : r_mode;
      w_pbase = IW'(nxt_beat) << LW;
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      localparam logic [IW-1:0] C_OFF = IW'((j * SINV) % N);
      logic [IW-1:0] w_idx;
      logic [IW-1:0] w_pos;
      assign w_idx     = w_acc + C_OFF;
      assign w_pos     = w_pbase + IW'(j);
      assign w_bits[j] = (w_mode == THERMO) ? ({1'b0, w_pos} < w_quota)
                                            : ({1'b0, w_idx} < w_quota);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_quota <= '0;
         r_mode  <= WEYL;
         bits    <= '0;
      end else if (start || step) begin
         r_acc   <= w_acc + C_STEP;
         r_quota <= w_quota;
         r_mode  <= w_mode;
         bits    <= w_bits;
      end
   end

endmodule
`default_nettype wire

// File: rtl/weyl_sng_stream.sv
`default_nettype none
// ============================================================================
// Module   : weyl_sng_stream
// Purpose  : Multi-channel streaming stochastic bitstream generator (Weyl or unary).
// Revision : 1.0 - initial release
// ============================================================================
module weyl_sng_stream
   import weyl_pkg::*;
#(
   parameter int BITSTREAM = 64,
   parameter int LANES     = 8,
   parameter int CHANNELS  = 2,
   parameter int BASE      = 61,
   parameter int STRIDE    = 17,
   parameter int BASE_STEP = 23
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic                                         in_mode,
   input  logic [CHANNELS*($clog2(BITSTREAM)+1)-1:0]    in_quota,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [CHANNELS*LANES-1:0]                    out_bits,
   output logic [$clog2(BITSTREAM/LANES)-1:0]           out_beat,
   output logic                                         out_last
);

   localparam int QW    = $clog2(BITSTREAM) + 1;
   localparam int BEATS = BITSTREAM / LANES;
   localparam int BW    = $clog2(BEATS);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [BW-1:0] r_beat;
   logic [BW-1:0] w_beat_nxt;
   logic          r_last;
   logic          w_accept;
   logic          w_consume;
   logic          w_step;

   // rst gates in_ready so no request is taken during a reset cycle
   assign in_ready  = !rst && ((r_state == IDLE) || (out_ready && r_last));
   assign out_valid = (r_state == STREAM);
   assign out_beat  = r_beat;
   assign out_last  = r_last;

   always_comb begin
      w_accept    = in_valid && in_ready;
      w_consume   = out_valid && out_ready;
      w_step      = w_consume && !r_last;
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = STREAM;
               w_beat_nxt  = '0;
            end
         end
         STREAM: begin
            if (w_consume) begin
               if (!r_last) begin
                  w_beat_nxt = r_beat + BW'(1);
               end else if (w_accept) begin
                  w_beat_nxt = '0;
               end else begin
                  w_state_nxt = IDLE;
                  w_beat_nxt  = '0;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_last  <= (w_state_nxt == STREAM) && (w_beat_nxt == BW'(BEATS - 1));
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      localparam int C_STRIDE = chan_stride(STRIDE, c);
      localparam int C_SINV   = modinv_pow2(C_STRIDE, BITSTREAM);
      localparam int C_BASE   = chan_base(BASE, BASE_STEP, c, BITSTREAM);
      localparam int C_IDX0   = chan_idx0(C_BASE, C_SINV, BITSTREAM);

      weyl_lane_gen #(
         .N     (BITSTREAM),
         .LANES (LANES),
         .SINV  (C_SINV),
         .IDX0  (C_IDX0)
      ) u_gen (
         .clk      (clk),
         .rst      (rst),
         .start    (w_accept),
         .step     (w_step),
         .mode     (in_mode),
         .quota    (in_quota[c*QW +: QW]),
         .nxt_beat (w_beat_nxt),
         .bits     (out_bits[c*LANES +: LANES])
      );
   end

endmodule
`default_nettype wire
